vga_counter: RTL
================

VGA_COUNTER -- requirements
Module: vga_counter

Interface
REQ-001 SHALL have parameter HTOTAL, default 10'd800, pixels per line including porches and sync.
REQ-002 SHALL have parameter VTOTAL, default 10'd525, lines per frame including porches and sync.
REQ-003 SHALL have parameter CLK_DIV, default 2, system clocks per pixel; legal range 1..16.
REQ-004 SHALL have port clk_i  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port h_ena_i  input  1  horizontal count enable from the VGA timing FSM.
REQ-007 SHALL have port v_ena_i  input  1  vertical count enable from the VGA timing FSM.
REQ-008 SHALL have port h_rst_i  input  1  synchronous horizontal counter clear from the FSM.
REQ-009 SHALL have port v_rst_i  input  1  synchronous vertical counter clear from the FSM.
REQ-010 SHALL have port pix_tick_o  output  1  one-clock pixel strobe.
REQ-011 SHALL have port h_cnt_o  output  10  current pixel column, 0..HTOTAL-1.
REQ-012 SHALL have port v_cnt_o  output  10  current line, 0..VTOTAL-1.
REQ-013 SHALL have port line_end_o  output  1  one-clock pulse on horizontal wrap.
REQ-014 SHALL have port frame_end_o  output  1  one-clock pulse on vertical wrap.
REQ-015 SHALL have port frame_cnt_o  output  8  frame count; present only under VGA_CNT_FRAME_CNT_EN.

Function
REQ-016 Divider SHALL count 0..CLK_DIV-1 every clock and wrap to 0; pix_tick_o SHALL be registered and high for exactly one clock per wrap (constant 1 when CLK_DIV=1).
REQ-017 h_cnt_o SHALL change only in a clock where pix_tick_o=1, h_ena_i=1 or h_rst_i=1.
REQ-018 On pix_tick_o=1 and h_ena_i=1: h_cnt_o SHALL increment by 1; at HTOTAL-1 it SHALL wrap to 0.
REQ-019 line_end_o SHALL be registered and asserted exactly in the clock after a horizontal wrap (when h_cnt_o first reads 0); otherwise 0.
REQ-020 On a horizontal wrap with v_ena_i=1: v_cnt_o SHALL increment by 1; at VTOTAL-1 it SHALL wrap to 0 and frame_end_o SHALL pulse as in REQ-019.
REQ-021 v_cnt_o SHALL NOT change on a wrap with v_ena_i=0.
REQ-022 h_rst_i=1 SHALL clear h_cnt_o to 0 on the next edge regardless of tick or enable; clear SHALL take priority over increment, and no line_end_o pulse SHALL occur.
REQ-023 v_rst_i=1 SHALL clear v_cnt_o to 0 with priority over increment; no frame_end_o pulse SHALL occur.
REQ-024 h_rst_i and v_rst_i SHALL NOT reset the divider; pixel phase SHALL be preserved.
REQ-025 Counters SHALL never exceed HTOTAL-1 / VTOTAL-1. Wrap detection SHALL use >= so an out-of-range value also wraps to 0.
REQ-026 Latency: count outputs SHALL update in the same edge that samples the tick; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 rst_ni=0 SHALL immediately set the divider, h_cnt_o and v_cnt_o to 0, and set pix_tick_o, line_end_o, frame_end_o and frame_cnt_o to 0.
REQ-028 After rst_ni deasserts, the first pix_tick_o SHALL occur CLK_DIV clocks later.
REQ-029 Reset asserted mid-line SHALL abort any pending pulse; no line_end_o or frame_end_o SHALL appear after release until a real wrap.

Configuration
REQ-030 With VGA_CNT_FRAME_CNT_EN defined, frame_cnt_o SHALL increment by 1 (mod 256) in the same clock frame_end_o is asserted.
REQ-031 Without VGA_CNT_FRAME_CNT_EN, the frame_cnt_o port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Scenario 1: CLK_DIV=2, enables=1, release reset -> pix_tick_o high on clocks 2, 4, 6, ...; h_cnt_o reads 1 after the first tick.
REQ-033 Scenario 2: run 800 ticks -> h_cnt_o goes 799->0, line_end_o is high one clock, and v_cnt_o goes 0->1.
REQ-034 Scenario 3: run 800*525 ticks -> v_cnt_o goes 524->0 and frame_end_o is high one clock; with the macro, frame_cnt_o goes 0->1.
REQ-035 Scenario 4: h_rst_i=1 in the clock h_cnt_o=799 has a tick -> h_cnt_o=0, no line_end_o, v_cnt_o unchanged.
REQ-036 Scenario 5: v_ena_i=0 across three wraps -> v_cnt_o holds; h_ena_i=0 -> h_cnt_o holds while pix_tick_o keeps toggling.
REQ-037 Scenario 6: rst_ni pulsed low at h_cnt_o=400, v_cnt_o=200 -> outputs 0 asynchronously; first tick at CLK_DIV clocks after release.

Source files
------------

// File: rtl/vga_counter.sv
// -----------------------------------------------------------------------------
// vga_counter
//
// Pixel clock divider plus horizontal / vertical position counters for a VGA
// timing generator. The surrounding timing FSM gates counting with the
// enables and can clear either counter synchronously. Every output is driven
// directly from a flop.
//
// Parameters
//   HTOTAL   pixels per line, including porches and sync
//   VTOTAL   lines per frame, including porches and sync
//   CLK_DIV  system clocks per pixel (1..16)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   h_ena_i      horizontal count enable
//   v_ena_i      vertical count enable (sampled on a horizontal wrap)
//   h_rst_i      synchronous horizontal clear, beats increment
//   v_rst_i      synchronous vertical clear, beats increment
//   pix_tick_o   one-clock pixel strobe
//   h_cnt_o      pixel column, 0..HTOTAL-1
//   v_cnt_o      line number, 0..VTOTAL-1
//   line_end_o   one-clock pulse in the clock h_cnt_o first reads 0 after a wrap
//   frame_end_o  one-clock pulse in the clock v_cnt_o first reads 0 after a wrap
//   frame_cnt_o  8-bit frame counter (only with VGA_CNT_FRAME_CNT_EN)
//
// Build option
//   VGA_CNT_FRAME_CNT_EN  adds the frame_cnt_o port and its register.
// -----------------------------------------------------------------------------
module vga_counter #(
    parameter logic [9:0]  HTOTAL  = 10'd800,
    parameter logic [9:0]  VTOTAL  = 10'd525,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       h_ena_i,
    input  logic       v_ena_i,
    input  logic       h_rst_i,
    input  logic       v_rst_i,
    output logic       pix_tick_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       line_end_o,
    output logic       frame_end_o
`ifdef VGA_CNT_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt_o
`endif
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = HTOTAL - 10'd1;
    localparam logic [9:0] V_LAST   = VTOTAL - 10'd1;

    logic [3:0] div_q, div_d;
    logic       pix_tick_q, pix_tick_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       line_end_q, line_end_d;
    logic       frame_end_q, frame_end_d;
    logic       h_wrap, v_wrap;

    always_comb begin
        div_d       = div_q;
        pix_tick_d  = 1'b0;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        h_wrap      = 1'b0;
        v_wrap      = 1'b0;

        // The divider free-runs; the counter clears never touch it so the
        // pixel phase survives an FSM-driven line or frame restart.
        if (div_q >= DIV_LAST) begin
            div_d      = '0;
            pix_tick_d = 1'b1;
        end else begin
            div_d      = div_q + 4'd1;
        end

        // >= so a corrupted count still returns to 0 instead of running on.
        if (h_rst_i) begin
            h_cnt_d = '0;
        end else if (pix_tick_q && h_ena_i) begin
            if (h_cnt_q >= H_LAST) begin
                h_cnt_d = '0;
                h_wrap  = 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Vertical only advances on a genuine horizontal wrap, so a cleared
        // line never steps the line counter.
        if (v_rst_i) begin
            v_cnt_d = '0;
        end else if (h_wrap && v_ena_i) begin
            if (v_cnt_q >= V_LAST) begin
                v_cnt_d = '0;
                v_wrap  = 1'b1;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end

        line_end_d  = h_wrap;
        frame_end_d = v_wrap;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q       <= '0;
            pix_tick_q  <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            pix_tick_q  <= pix_tick_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign pix_tick_o  = pix_tick_q;
    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign line_end_o  = line_end_q;
    assign frame_end_o = frame_end_q;

`ifdef VGA_CNT_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Steps on the same edge that raises frame_end_o; wraps naturally at 256.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
